// File: rtl/warb_pkg.sv
// Shared definitions for the weighted round-robin credit arbiter:
// FSM state encoding and default parameter values.
package warb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } warb_state_t;

  localparam int DEF_NUM_REQ  = 8;
  localparam int DEF_WEIGHT_W = 4;

endpackage

// File: rtl/warb_rr_pick.sv
// Combinational wrap-around search: returns the first set bit of
// eligible at or after index start, wrapping past N-1 back to 0.
module warb_rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);

  localparam int IDX_W = $clog2(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   sum;

  // Duplicating the vector turns the wrap-around into a plain shift.
  assign doubled = {eligible, eligible} >> start;
  assign rotated = doubled[N-1:0];

  // Lowest set bit of the rotated vector is the distance from start.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = IDX_W'(i);
      end
    end
  end

  assign sum   = {1'b0, start} + {1'b0, offset};
  assign index = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : IDX_W'(sum);

endmodule

// File: rtl/warbiter_wrr_credit.sv
// Weighted round-robin arbiter with per-requester burst credits and a
// registered valid/ready grant output. Define WARB_LOCK_EN to compile in
// the lock feature that lets the current holder extend its burst.
module warbiter_wrr_credit
  import warb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         request_vector,
  input  logic [WEIGHT_W-1:0]        weight [NUM_REQ],
  input  logic                       lock,
  input  logic                       grant_ready,
  output logic                       grant_valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       burst_last
);

  localparam int IDX_W = $clog2(NUM_REQ);

  warb_state_t         state_reg;
  logic [IDX_W-1:0]    cur_reg;
  logic [IDX_W-1:0]    ptr_reg;
  logic [WEIGHT_W-1:0] cnt_reg;

  logic [NUM_REQ-1:0]  eligible;
  logic                slot;
  logic [WEIGHT_W-1:0] weight_cur;
  logic [WEIGHT_W-1:0] cnt_next;
  logic [IDX_W-1:0]    cur_plus1;
  logic [IDX_W-1:0]    pick_start;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                credit_hold;
  logic                lock_hold;
  logic                regrant;

  // A requester with zero weight is never eligible.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign eligible[gi] = request_vector[gi] && (weight[gi] != '0);
  end

  assign slot       = !grant_valid || grant_ready;
  assign weight_cur = weight[cur_reg];
  assign cur_plus1  = (cur_reg == IDX_W'(NUM_REQ - 1)) ? '0 : cur_reg + IDX_W'(1);
  assign pick_start = (state_reg == BURST) ? cur_plus1 : ptr_reg;

  // Saturating increment keeps cnt at weight while a lock extends the burst.
  assign cnt_next    = (cnt_reg < weight_cur) ? cnt_reg + WEIGHT_W'(1) : weight_cur;
  assign credit_hold = (state_reg == BURST) && eligible[cur_reg] && (cnt_reg < weight_cur);

`ifdef WARB_LOCK_EN
  // Lock extends the burst past its credit, but never revives weight 0.
  assign lock_hold = (state_reg == BURST) && lock && eligible[cur_reg];
`else
  // Lock port kept on the interface but left unconnected in this build.
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_hold   = 1'b0;
`endif

  assign regrant = credit_hold || lock_hold;

  warb_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .eligible (eligible),
    .start    (pick_start),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // Burst FSM and registered grant outputs; everything holds outside a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
      grant_id    <= '0;
      burst_last  <= 1'b0;
    end else if (slot) begin
      if (regrant) begin
        cnt_reg     <= cnt_next;
        grant_valid <= 1'b1;
        grant       <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << cur_reg;
        grant_id    <= cur_reg;
        burst_last  <= (cnt_next == weight_cur);
      end else begin
        // Ending a burst moves the rotation pointer past the old holder.
        if (state_reg == BURST) begin
          ptr_reg <= cur_plus1;
        end
        if (pick_found) begin
          state_reg   <= BURST;
          cur_reg     <= pick_idx;
          cnt_reg     <= WEIGHT_W'(1);
          grant_valid <= 1'b1;
          grant       <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_idx;
          grant_id    <= pick_idx;
          burst_last  <= (weight[pick_idx] == WEIGHT_W'(1));
        end else begin
          state_reg   <= IDLE;
          grant_valid <= 1'b0;
          grant       <= '0;
          burst_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_warbiter_wrr_credit.sv
// Self-checking bench for warbiter_wrr_credit with NUM_REQ=4, WEIGHT_W=4.
// Lock expectations follow WARB_LOCK_EN as compiled.
module tb_warbiter_wrr_credit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request_vector;
  logic [3:0] weight [4];
  logic       lock;
  logic       grant_ready;
  logic       grant_valid;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       burst_last;

  typedef struct packed {
    logic [1:0] id;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   errors  = 0;

  warbiter_wrr_credit #(
    .NUM_REQ  (4),
    .WEIGHT_W (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .request_vector (request_vector),
    .weight         (weight),
    .lock           (lock),
    .grant_ready    (grant_ready),
    .grant_valid    (grant_valid),
    .grant          (grant),
    .grant_id       (grant_id),
    .burst_last     (burst_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    request_vector = '0;
    lock           = 1'b0;
    grant_ready    = 1'b1;
    for (int i = 0; i < 4; i++) weight[i] = 4'd1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    request_vector = 4'b1111;
    grant_ready    = 1'b1;
    lock           = 1'b0;
    for (int i = 0; i < 4; i++) weight[i] = 4'd1;
    cycle();
    cycle();
    vectors++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", grant_valid);
    end
    vectors++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_grant: got %b want 0000", grant);
    end
    vectors++;
    if (grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_id: got %0d want 0", grant_id);
    end
    vectors++;
    if (burst_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_last: got %b want 0", burst_last);
    end
    $display("reset: valid=%b grant=%b id=%0d last=%b", grant_valid, grant, grant_id, burst_last);
    reset          = 1'b0;
    request_vector = '0;
  endtask

  task automatic test_wrr_sequence();
    int   budget;
    exp_t e;
    do_reset();
    weight[0] = 4'd1; weight[1] = 4'd2; weight[2] = 4'd3; weight[3] = 4'd1;
    request_vector = 4'b1111;
    grant_ready    = 1'b1;
    sb_q.push_back('{2'd0, 1'b1});
    sb_q.push_back('{2'd1, 1'b0});
    sb_q.push_back('{2'd1, 1'b1});
    sb_q.push_back('{2'd2, 1'b0});
    sb_q.push_back('{2'd2, 1'b0});
    sb_q.push_back('{2'd2, 1'b1});
    sb_q.push_back('{2'd3, 1'b1});
    sb_q.push_back('{2'd0, 1'b1});
    sb_q.push_back('{2'd1, 1'b0});
    sb_q.push_back('{2'd1, 1'b1});
    budget = 0;
    while (sb_q.size() > 0 && budget < 100) begin
      if (grant_valid && grant_ready) begin
        e = sb_q.pop_front();
        vectors++;
        $display("wrr: grant id=%0d grant=%b last=%b", grant_id, grant, burst_last);
        if (grant_id !== e.id || grant !== (4'b0001 << e.id) || burst_last !== e.last) begin
          errors++;
          $display("FAIL wrr_grant: got id=%0d grant=%b last=%b want id=%0d last=%b",
                   grant_id, grant, burst_last, e.id, e.last);
        end
      end
      cycle();
      budget++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL wrr_timeout: got %0d grants outstanding want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_zero_weight();
    do_reset();
    weight[0] = 4'd1; weight[1] = 4'd1; weight[2] = 4'd0; weight[3] = 4'd1;
    request_vector = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      cycle();
      vectors++;
      if (grant_valid !== 1'b0 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL zero_weight: cycle %0d got valid=%b grant=%b want 0/0000", i, grant_valid, grant);
      end
    end
    $display("zero_weight: 20 cycles, valid=%b", grant_valid);
  endtask

  task automatic test_stall();
    int   budget;
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) weight[i] = 4'd3;
    request_vector = 4'b0010;
    grant_ready    = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (grant_valid !== 1'b1 || grant !== 4'b0010 || grant_id !== 2'd1 || burst_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got valid=%b grant=%b id=%0d last=%b want 1/0010/1/0",
                 i, grant_valid, grant, grant_id, burst_last);
      end
      $display("stall: valid=%b grant=%b ready=%b", grant_valid, grant, grant_ready);
      cycle();
    end
    grant_ready = 1'b1;
    sb_q.push_back('{2'd1, 1'b0});
    sb_q.push_back('{2'd1, 1'b0});
    sb_q.push_back('{2'd1, 1'b1});
    budget = 0;
    while (sb_q.size() > 0 && budget < 50) begin
      if (grant_valid && grant_ready) begin
        e = sb_q.pop_front();
        vectors++;
        $display("stall: grant id=%0d grant=%b last=%b", grant_id, grant, burst_last);
        if (grant_id !== e.id || grant !== (4'b0001 << e.id) || burst_last !== e.last) begin
          errors++;
          $display("FAIL stall_grant: got id=%0d grant=%b last=%b want id=%0d last=%b",
                   grant_id, grant, burst_last, e.id, e.last);
        end
      end
      cycle();
      budget++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL stall_timeout: got %0d grants outstanding want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 4; i++) weight[i] = 4'd3;
    request_vector = 4'b0110;
    grant_ready    = 1'b1;
    cycle();
    vectors++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL drop_first: got valid=%b id=%0d want 1/1", grant_valid, grant_id);
    end
    $display("drop: grant id=%0d valid=%b", grant_id, grant_valid);
    request_vector = 4'b0100;
    cycle();
    vectors++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd2 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL drop_next: got valid=%b id=%0d grant=%b want 1/2/0100", grant_valid, grant_id, grant);
    end
    $display("drop: grant id=%0d valid=%b", grant_id, grant_valid);
  endtask

  task automatic test_lock();
    int   budget;
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) weight[i] = 4'd1;
    request_vector = 4'b0011;
    lock           = 1'b1;
    grant_ready    = 1'b1;
`ifdef WARB_LOCK_EN
    sb_q.push_back('{2'd0, 1'b1});
    sb_q.push_back('{2'd0, 1'b1});
    sb_q.push_back('{2'd0, 1'b1});
    sb_q.push_back('{2'd0, 1'b1});
`else
    sb_q.push_back('{2'd0, 1'b1});
    sb_q.push_back('{2'd1, 1'b1});
    sb_q.push_back('{2'd0, 1'b1});
    sb_q.push_back('{2'd1, 1'b1});
`endif
    budget = 0;
    while (sb_q.size() > 0 && budget < 50) begin
      if (grant_valid && grant_ready) begin
        e = sb_q.pop_front();
        vectors++;
        $display("lock: grant id=%0d grant=%b last=%b", grant_id, grant, burst_last);
        if (grant_id !== e.id || grant !== (4'b0001 << e.id) || burst_last !== e.last) begin
          errors++;
          $display("FAIL lock_grant: got id=%0d grant=%b last=%b want id=%0d last=%b",
                   grant_id, grant, burst_last, e.id, e.last);
        end
      end
      cycle();
      budget++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL lock_timeout: got %0d grants outstanding want 0", sb_q.size());
      sb_q.delete();
    end
    lock = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int budget;
    do_reset();
    for (int i = 0; i < 4; i++) weight[i] = 4'd3;
    request_vector = 4'b1111;
    grant_ready    = 1'b1;
    cycle();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    vectors++;
    if (grant_valid !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_clear: got valid=%b grant=%b want 0/0000", grant_valid, grant);
    end
    $display("midreset: valid=%b grant=%b", grant_valid, grant);
    reset  = 1'b0;
    budget = 0;
    cycle();
    while (!grant_valid && budget < 20) begin
      cycle();
      budget++;
    end
    vectors++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0 || burst_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_first: got valid=%b id=%0d last=%b want 1/0/0", grant_valid, grant_id, burst_last);
    end
    $display("midreset: first grant id=%0d last=%b", grant_id, burst_last);
  endtask

  initial begin
    reset          = 1'b1;
    request_vector = '0;
    lock           = 1'b0;
    grant_ready    = 1'b1;
    for (int i = 0; i < 4; i++) weight[i] = 4'd1;
    test_reset();
    test_wrr_sequence();
    test_zero_weight();
    test_stall();
    test_drop();
    test_lock();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/warbiter_wrr_credit.md
WARBITER_WRR_CREDIT -- requirements
Module: warbiter_wrr_credit

Interface
REQ-001 Parameter NUM_REQ, default 8, SHALL set the number of requesters (legal range 2 to 32).
REQ-002 Parameter WEIGHT_W, default 4, SHALL set the width of each weight and of the burst counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 request_vector  input  NUM_REQ  SHALL carry one request bit per requester, held by the requester until its grant is accepted.
REQ-006 weight  input  NUM_REQ x WEIGHT_W (unpacked array)  SHALL give the maximum consecutive grants per burst for each requester; 0 disables that requester.
REQ-007 lock  input  1  SHALL request extension of the current burst (used only under REQ-027).
REQ-008 grant_ready  input  1  SHALL indicate that downstream accepts the presented grant.
REQ-009 grant_valid  output  1  SHALL flag a valid registered grant.
REQ-010 grant  output  NUM_REQ  SHALL be the one-hot grant, all-zero when grant_valid is low.
REQ-011 grant_id  output  $clog2(NUM_REQ)  SHALL be the binary index of the granted requester.
REQ-012 burst_last  output  1  SHALL be high when the presented grant is the last one of its burst by weight (cnt equals weight).

Function
REQ-013 Eligible set SHALL be request_vector AND (weight[i] != 0).
REQ-014 Decision slot SHALL exist in any cycle with (!grant_valid || grant_ready); outside a slot, all outputs and state SHALL hold unchanged.
REQ-015 Latency: eligible request in a slot at cycle t SHALL produce grant_valid at t+1; with grant_ready tied high, one grant per cycle.
REQ-016 FSM states IDLE and BURST; state registers: cur (holder), ptr (rotation pointer), cnt (grants issued in burst).
REQ-017 In BURST, if eligible[cur] and cnt < weight[cur], the slot SHALL regrant cur and increment cnt.
REQ-018 Otherwise the slot SHALL end the burst and pick the first eligible index at or after (cur+1) mod NUM_REQ, wrapping; cnt is set to 1, and state goes BURST.
REQ-019 In IDLE, the pick SHALL start at ptr; ptr SHALL be updated to (cur+1) mod NUM_REQ at every burst end.
REQ-020 With no eligible request in a slot: grant_valid SHALL drop to 0, state to IDLE, and ptr is retained.
REQ-021 Weight SHALL be sampled at each slot; a weight lowered to ≤ cnt SHALL end the burst at that slot.
REQ-022 A holder deasserting its request SHALL end the burst at the next slot (work-conserving; no idle cycle inserted).
REQ-023 A grant with grant_valid high and grant_ready low SHALL keep grant, grant_id and burst_last stable until accepted.

Reset
REQ-024 On reset: grant_valid=0, grant=0, grant_id=0, burst_last=0, state=IDLE, ptr=0, cur=0, cnt=0.
REQ-025 Reset mid-burst or mid-stall SHALL abandon the pending grant, with no carry-over of cnt.

Configuration
REQ-026 The macro WARB_LOCK_EN SHALL compile the lock feature in.
REQ-027 With WARB_LOCK_EN defined: in BURST, if lock is high and request_vector[cur] is high, the slot SHALL regrant cur regardless of cnt, with cnt saturating at weight[cur]. The lock SHALL NOT override weight 0.
REQ-028 Without WARB_LOCK_EN: the lock port SHALL still exist but SHALL be ignored, with no logic behind it.

Structure
REQ-029 Package warb_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-030 Sub-module warb_rr_pick (combinational; inputs: eligible vector and start index; outputs: found and index) SHALL perform the wrap-around first-eligible search.

Verification (NUM_REQ=4, WEIGHT_W=4)
REQ-031 Reset asserted mid-burst -> next cycle grant_valid=0, grant=0; after release, with all requests high, the first grant_id=0.
REQ-032 All requests high, weight={1,2,3,1} (req0..3), ready=1 -> grant_id sequence 0,1,1,2,2,2,3,0,1,1 and burst_last high on 0,2nd 1,3rd 2,3.
REQ-033 Only req2 high with weight[2]=0 -> grant_valid stays 0 for 20 cycles.
REQ-034 Grant to req1 (weight 3) presented and ready low for 3 cycles -> grant=4'b0010 stable; after ready rises, the next grant is req1 with cnt=2.
REQ-035 req1 (weight 3) drops after its first accepted grant, req2 requesting -> the following cycle grant_id=2, with no bubble.
REQ-036 req0 and req1 high, weight 1 each, lock high -> with WARB_LOCK_EN the grants are 0,0,0,...; without it they are 0,1,0,1.
